// File: rtl/selen_mem_responder.sv
// Word-addressed RAM responder for the core's instruction and data req/ack ports.
// Each port runs its own IDLE/WAIT/ACK sequencer with a fixed wait-state count.
module selen_mem_responder #(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int unsigned I_LATENCY  = 1,
    parameter int unsigned D_LATENCY  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_val,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ack,
    output logic [31:0] i_ack_rdata,
    input  logic        d_req_val,
    input  logic [31:0] d_req_addr,
    input  logic [2:0]  d_req_cop,
    input  logic [31:0] d_req_wdata,
    input  logic [2:0]  d_req_size,
    output logic        d_req_ack,
    output logic [31:0] d_ack_rdata,
    input  logic        err_clr,
    output logic        err_misalign,
    output logic        err_range
);

    localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0]  I_CNT0 = 4'(I_LATENCY - 1);
    localparam logic [3:0]  D_CNT0 = 4'(D_LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

    // NOTE: RAM contents are deliberately not reset; only control state is.
    logic [31:0] r_mem [DEPTH];

    state_t      r_i_state, r_d_state;
    logic [3:0]  r_i_cnt, r_d_cnt;
    logic        r_run;

    logic        w_i_borrow, w_d_borrow;
    logic [31:0] w_i_off, w_d_off;
    logic        w_i_inrng, w_d_inrng;
    logic [DEPTH_LOG2-1:0] w_i_idx, w_d_idx;
    logic        w_i_accept, w_d_accept;
    logic [3:0]  w_d_be;
    logic        w_d_mis;
    logic        w_d_we;
    logic        w_unused;

    // A borrow out of the subtraction flags addresses below BASE_ADDR.
    assign {w_i_borrow, w_i_off} = {1'b0, i_req_addr} - {1'b0, BASE_ADDR};
    assign {w_d_borrow, w_d_off} = {1'b0, d_req_addr} - {1'b0, BASE_ADDR};
    assign w_i_inrng = !w_i_borrow && ((w_i_off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign w_d_inrng = !w_d_borrow && ((w_d_off >> (DEPTH_LOG2 + 2)) == 32'd0);
    assign w_i_idx   = w_i_off[DEPTH_LOG2+1:2];
    assign w_d_idx   = w_d_off[DEPTH_LOG2+1:2];

    // r_run keeps requests held across reset from being accepted on the release edge.
    assign w_i_accept = r_run && (r_i_state == ST_IDLE) && i_req_val;
    assign w_d_accept = r_run && (r_d_state == ST_IDLE) && d_req_val;

    assign w_unused = ^d_req_cop[2:1];

    always_comb begin
        w_d_be  = 4'b0000;
        w_d_mis = 1'b0;
        case (d_req_size)
            3'd0, 3'd4: w_d_be = 4'b0001 << d_req_addr[1:0];
            3'd1, 3'd5: begin
                w_d_be  = 4'b0011 << {d_req_addr[1], 1'b0};
                w_d_mis = d_req_addr[0];
            end
            3'd2: begin
                w_d_be  = 4'b1111;
                w_d_mis = |d_req_addr[1:0];
            end
            default: w_d_mis = 1'b1;
        endcase
    end

    assign w_d_we = w_d_accept && d_req_cop[0] && w_d_inrng && !w_d_mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_run <= 1'b0;
        else        r_run <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (w_d_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_d_be[b]) r_mem[w_d_idx][8*b +: 8] <= d_req_wdata[8*b +: 8];
            end
        end
    end

    // NOTE: the read below samples r_mem before this edge's write lands, giving read-before-write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i_state   <= ST_IDLE;
            r_i_cnt     <= 4'd0;
            i_req_ack   <= 1'b0;
            i_ack_rdata <= 32'd0;
        end else begin
            i_req_ack <= 1'b0;
            case (r_i_state)
                ST_IDLE: if (w_i_accept) begin
                    i_ack_rdata <= w_i_inrng ? r_mem[w_i_idx] : 32'd0;
                    r_i_cnt     <= I_CNT0;
                    if (I_LATENCY == 1) begin
                        r_i_state <= ST_ACK;
                        i_req_ack <= 1'b1;
                    end else begin
                        r_i_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_i_cnt <= r_i_cnt - 4'd1;
                    if (r_i_cnt == 4'd1) begin
                        r_i_state <= ST_ACK;
                        i_req_ack <= 1'b1;
                    end
                end
                default: r_i_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d_state   <= ST_IDLE;
            r_d_cnt     <= 4'd0;
            d_req_ack   <= 1'b0;
            d_ack_rdata <= 32'd0;
        end else begin
            d_req_ack <= 1'b0;
            case (r_d_state)
                ST_IDLE: if (w_d_accept) begin
                    d_ack_rdata <= w_d_inrng ? r_mem[w_d_idx] : 32'd0;
                    r_d_cnt     <= D_CNT0;
                    if (D_LATENCY == 1) begin
                        r_d_state <= ST_ACK;
                        d_req_ack <= 1'b1;
                    end else begin
                        r_d_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    r_d_cnt <= r_d_cnt - 4'd1;
                    if (r_d_cnt == 4'd1) begin
                        r_d_state <= ST_ACK;
                        d_req_ack <= 1'b1;
                    end
                end
                default: r_d_state <= ST_IDLE;
            endcase
        end
    end

    // A new error in the same cycle wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_misalign <= 1'b0;
            err_range    <= 1'b0;
        end else begin
            err_misalign <= (w_d_accept && w_d_mis) || (err_misalign && !err_clr);
            err_range    <= (w_i_accept && !w_i_inrng) || (w_d_accept && !w_d_inrng)
                            || (err_range && !err_clr);
        end
    end

endmodule

// File: doc/selen_mem_responder.md
# selen_mem_responder

Memory-side responder for the core's instruction and data request/acknowledge interfaces. It sits opposite the core wrapper, accepts held-valid requests on both ports, and services them from an internal word-addressed RAM. Each port acknowledges after a fixed, per-port wait-state count, and data writes use per-byte lane enables. Its main use is as the simulation and FPGA memory model for the integrated core, and as the reference slave for the bus protocol.

## Interface
- DEPTH_LOG2, 12: RAM holds 2^DEPTH_LOG2 32-bit words.
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be word-aligned.
- I_LATENCY, 1: instruction-port cycles from acceptance to ack; legal range 1..15.
- D_LATENCY, 1: data-port cycles from acceptance to ack; legal range 1..15.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- i_req_val  in  1  instruction request valid; held until ack.
- i_req_addr  in  32  instruction byte address; stable while valid.
- i_req_ack  out  1  one-cycle acknowledge.
- i_ack_rdata  out  32  fetched word; valid while i_req_ack=1.
- d_req_val  in  1  data request valid; held until ack.
- d_req_addr  in  32  data byte address.
- d_req_cop  in  3  bit0 = write; bit1 = non-cacheable (ignored); bit2 = reserved (ignored).
- d_req_wdata  in  32  store data, already lane-replicated by the core.
- d_req_size  in  3  0/4 byte, 1/5 half, 2 word, 3/6/7 illegal.
- d_req_ack  out  1  one-cycle acknowledge.
- d_ack_rdata  out  32  raw aligned word, with no shift or extension; valid while d_req_ack=1.
- err_clr  in  1  synchronous clear of the error flags.
- err_misalign  out  1  sticky misaligned or illegal-size data access.
- err_range  out  1  sticky out-of-range access on either port.

## Operation
- Each port has an independent FSM with three states: IDLE, WAIT and ACK, plus a 4-bit counter.
- IDLE:
  - If req_val=1 at a clock edge, the request is accepted.
  - At acceptance, the address is latched, the RAM word is read into the rdata register, and counter = LATENCY-1.
  - The next state is ACK when LATENCY=1, otherwise WAIT.
- WAIT: the counter decrements each cycle; the FSM moves to ACK when the counter reaches 1.
- ACK: ack=1 for exactly one cycle, then unconditionally IDLE. A request still visible during the ACK cycle is not re-accepted.
- Word index = (addr - BASE_ADDR) >> 2. Out of range means index >= 2^DEPTH_LOG2 or addr < BASE_ADDR.
  - An out-of-range read returns 32'h0.
  - An out-of-range write is dropped.
  - Both set err_range.
- Data writes (cop[0]=1) commit at the acceptance edge, with byte enables decoded from size and addr[1:0]:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four lanes.
- A write ack returns the pre-write word on d_ack_rdata.
- Misaligned accesses are a half with addr[0]=1 or a word with addr[1:0]!=0. Misaligned accesses and illegal sizes:
  - No write.
  - Read data is still returned.
  - err_misalign is set.
  - The access is still acked.
- Instruction-port read and data-port write to the same word at the same edge: the fetch returns the old word (read-before-write).
- Data-port accesses to the same word back-to-back: the second access sees the first write.
- Error flags: set has priority over err_clr in the same cycle.

## Timing
- Reset values:
  - i_req_ack=0, d_req_ack=0.
  - i_ack_rdata=0, d_ack_rdata=0.
  - err_misalign=0, err_range=0.
  - Both FSMs in IDLE, counters 0.
  - RAM contents are not reset.
- Latency: acceptance at edge N, ack high during cycle N+LATENCY. Throughput per port is one request per LATENCY+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- rdata registers hold their value until the next acceptance.
- The two ports are fully concurrent and never stall each other.
- Reset asserted mid-transaction: pending acks are abandoned.
  - A write that was already accepted stays committed.
  - A write that was not yet accepted never happens.
- req_val dropping during WAIT is a protocol violation. The FSM still completes and acks.

## Test plan
- Word write then read, D_LATENCY=1: write 32'hDEAD_BEEF at 0x10, then read 0x10.
  - Write ack one cycle after acceptance.
  - Read returns 32'hDEAD_BEEF.
- Byte and half lanes: write 32'h1111_1111 to 0x20, then byte 32'hAAAA_AAAA at 0x21, then half 32'hBBBB_BBBB at 0x22. A read of 0x20 returns 32'hBBBB_AA11.
- Latency, I_LATENCY=3, i_req_val held high: one ack every 4 cycles, the first exactly 3 cycles after the acceptance edge, with addresses stepping 0x0, 0x4, 0x8.
- Errors:
  - Half write at 0x31: memory unchanged, err_misalign=1, still acked.
  - Read at BASE_ADDR + 4*2^DEPTH_LOG2: rdata=0, err_range=1.
  - err_clr clears both flags.
- Same-edge conflict: instruction read and data write to 0x40 accepted on the same edge. The fetch returns the old value; a later fetch returns the new value.
- Reset mid-WAIT with D_LATENCY=4: rst_n pulsed two cycles after acceptance.
  - No ack, all outputs 0.
  - The accepted write is present in memory after reset.
